param_store: RTL
================

Name: param_store

Overview:
- Parametrised, writable successor to the fixed 8x16 parameter ROM used by the neural-circuit datapath.
- Holds per-neuron weights/thresholds in a flop array.
- Loaded through a simple write port.
- Read through a 4-phase req/ack handshake that matches the asynchronous stage interfaces, with optional auto-incrementing burst reads.
- Sits between the configuration loader and the neuron compute stages.

Parameters:
- DATA_W, 16, word width.
- DEPTH, 8, number of words; 1 <= DEPTH <= 2^ADDR_W.
- ADDR_W, 3, address width.
- LEN_W, 3, burst-length field width.
- IDLE_VAL, {DATA_W{1'b1}}, value driven on dataOut whenever rdAck is low.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wrEn  in  1  write strobe, one word per cycle.
- wrAddr  in  ADDR_W  write address.
- wrData  in  DATA_W  write data.
- rdReq  in  1  4-phase read request; rdAddr and burstLen must be stable while it is high.
- rdAddr  in  ADDR_W  start address, sampled only on the request that opens a transaction.
- burstLen  in  LEN_W  extra words after the first; 0 means a single-word read. Sampled with rdAddr.
- rdAck  out  1  4-phase acknowledge.
- dataOut  out  DATA_W  read data; valid while rdAck=1, otherwise IDLE_VAL.
- busy  out  1  high from transaction open until the final ack falls.
- lastOut  out  1  high alongside rdAck on the final word of a transaction.

Behaviour:
- Reset (rst=1 at an edge):
  - All DEPTH words cleared to 0.
  - FSM forced to IDLE.
  - rdAck=0, busy=0, lastOut=0, dataOut=IDLE_VAL, address and remaining counters cleared.
  - Reset overrides any write or read in the same cycle.
  - Reset mid-transaction aborts it; the master must return rdReq low before issuing a new request.
- Writes:
  - At an edge with wrEn=1 and wrAddr<DEPTH: mem[wrAddr] <= wrData.
  - wrAddr>=DEPTH: write is ignored.
  - Writes are allowed in every state and do not affect the handshake.
- FSM states: IDLE, ACK_HI, ACK_LO.
  - IDLE, rdReq=1 at edge:
    - Latch ptr <= rdAddr and rem <= burstLen.
    - dataOut <= word(rdAddr); rdAck <= 1; busy <= 1; lastOut <= (burstLen==0).
    - Go to ACK_HI.
    - Latency: one edge from rdReq sampled high to rdAck high.
  - ACK_HI, rdReq=0 at edge:
    - rdAck <= 0; dataOut <= IDLE_VAL; lastOut <= 0.
    - If rem==0: busy <= 0, go to IDLE.
    - Else: ptr <= (ptr+1) mod DEPTH, rem <= rem-1, go to ACK_LO.
  - ACK_HI, rdReq=1 at edge: hold all outputs.
  - ACK_LO, rdReq=1 at edge:
    - dataOut <= word(ptr); rdAck <= 1; lastOut <= (rem==0); go to ACK_HI.
    - rdAddr and burstLen are ignored.
- word(a):
  - Returns mem[a] if a<DEPTH, else 0.
  - Read-before-write: a write to the same address at the same edge is not visible until the following read.
- dataOut is registered at the ack edge. A later write to that address does not change dataOut while rdAck=1.
- Burst address wraps modulo DEPTH. Example: DEPTH=8, start 6, burstLen 3 reads 6, 7, 0, 1.
- Maximum burst is 2^LEN_W words. burstLen greater than DEPTH-1 simply rereads wrapped words.
- Each word costs at least 2 cycles: rdAck high, then low.

Test Plan:
1. Reset, then issue a single read at address 5 -> rdAck rises one edge after rdReq; dataOut=0x0000; lastOut=1. After rdReq falls, rdAck=0, dataOut=0xFFFF, busy=0.
2. Write 0x1234 to address 2 and 0xBEEF to address 3, then read address 2 with burstLen=1 -> 0x1234 (lastOut=0), then 0xBEEF (lastOut=1). busy falls with the second ack.
3. Load addresses 0..7 with value 0x0A00+addr; start address 6, burstLen=3 -> words 0x0A06, 0x0A07, 0x0A00, 0x0A01 (wrap). A rdAddr change mid-burst has no effect.
4. While rdAck=1 for address 4, write 0x5555 to address 4 -> dataOut stays at the old value. The next read of address 4 returns 0x5555. A same-edge write and read open returns the old value.
5. Assert rst while in ACK_HI mid-burst -> next cycle rdAck=0, busy=0, dataOut=0xFFFF, all words 0. A new read after rdReq toggles low then high returns 0.
6. DEPTH=6, ADDR_W=3 build: write to address 7 is ignored; read of address 7 returns 0x0000; burst from address 5 with burstLen=1 reads addresses 5 then 0.

Source files
------------

// File: rtl/param_store.sv
// param_store: writable per-neuron parameter store (weights/thresholds).
// A flop array is loaded through a one-word-per-cycle write port and read through a 4-phase
// req/ack handshake with optional auto-incrementing, wrapping burst reads.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   wrEn      write strobe
//   wrAddr    write address (ignored when >= DEPTH)
//   wrData    write data
//   rdReq     4-phase read request; rdAddr/burstLen stable while high
//   rdAddr    burst start address, sampled when a transaction opens
//   burstLen  extra words after the first (0 = single word)
//   rdAck     4-phase acknowledge
//   dataOut   read data while rdAck=1, IDLE_VAL otherwise
//   busy      high from transaction open until the final ack falls
//   lastOut   high alongside rdAck on the final word
module param_store #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       DEPTH    = 8,
  parameter int unsigned       ADDR_W   = 3,
  parameter int unsigned       LEN_W    = 3,
  parameter logic [DATA_W-1:0] IDLE_VAL = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] rdAddr,
  input  logic [LEN_W-1:0]  burstLen,
  output logic              rdAck,
  output logic [DATA_W-1:0] dataOut,
  output logic              busy,
  output logic              lastOut
);

  typedef enum logic [1:0] {StIdle, StAckHi, StAckLo} state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              ack_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              last_q;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Unmapped addresses read as zero. Reads see the pre-edge array contents, so a same-edge
  // write only becomes visible on a later read.
  function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
    if (addr_ok(a)) begin
      return mem_q[a];
    end
    return '0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wrEn && addr_ok(wrAddr)) begin
      mem_q[wrAddr] <= wrData;
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      rem_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= IDLE_VAL;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rdReq) begin
            ptr_q   <= rdAddr;
            rem_q   <= burstLen;
            data_q  <= word(rdAddr);
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
            last_q  <= (burstLen == '0);
            state_q <= StAckHi;
          end
        end
        StAckHi: begin
          if (!rdReq) begin
            ack_q  <= 1'b0;
            data_q <= IDLE_VAL;
            last_q <= 1'b0;
            if (rem_q == '0) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              // Wrap modulo DEPTH, which need not be a power of two.
              ptr_q   <= ADDR_W'((32'(ptr_q) + 32'd1) % DEPTH);
              rem_q   <= rem_q - 1'b1;
              state_q <= StAckLo;
            end
          end
        end
        StAckLo: begin
          if (rdReq) begin
            data_q  <= word(ptr_q);
            ack_q   <= 1'b1;
            last_q  <= (rem_q == '0);
            state_q <= StAckHi;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdAck   = ack_q;
  assign dataOut = data_q;
  assign busy    = busy_q;
  assign lastOut = last_q;

endmodule
